// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a count-prefixed byte stream into 32-bit RAM writes and pads the rest with HALT_WORD.
// Optional checksum byte after the data words: define IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int          ADDR_W    = 5,
    parameter int          DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [2:0]        dbg_state
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM = 3'd3,
`endif
        S_FILL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t S_POST = S_CKSUM;
`else
    localparam state_t S_POST = S_FILL;
`endif

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic xfer;
    assign xfer = byte_valid & byte_ready_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
                    xor_d   = 8'h00;
`endif
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    idx_d  = 8'd0;
                    bcnt_d = 2'd0;
                    if (byte_data > DEPTH_B) begin
                        n_d   = DEPTH_B;
                        err_d = 1'b1;
                    end else begin
                        n_d = byte_data;
                    end
                    state_d = (byte_data == 8'd0) ? S_POST : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    xor_d  = xor_q ^ byte_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {byte_data, asm_q[23:8]};
                    // asm_q already holds {b2,b1,b0}; the 4th byte completes the word
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(idx_q);
                        wr_data_d = {byte_data, asm_q};
                        idx_d     = idx_q + 8'd1;
                        if (idx_q == n_q - 8'd1) state_d = S_POST;
                    end
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (xfer) begin
                    if (byte_data != xor_q) err_d = 1'b1;
                    state_d = S_FILL;
                end
            end
`endif
            S_FILL: begin
                if (idx_q < DEPTH_B) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(idx_q);
                    wr_data_d = HALT_WORD;
                    idx_d     = idx_q + 8'd1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_COUNT) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CKSUM_EN
                       || (state_d == S_CKSUM)
`endif
                       ;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= 8'd0;
            idx_q        <= 8'd0;
            bcnt_q       <= 2'd0;
            asm_q        <= 24'd0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_hold   = cpu_hold_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a reference model fills an expected-write queue, a monitor pops it on every wr_en.
// Handshake: a byte moves when byte_valid and byte_ready are both high at a rising clk edge.
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int W      = ADDR_W + 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, wr_en, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        dbg_state;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .cpu_hold(cpu_hold), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int write_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) xfer_cnt++;
      if (wr_en) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr_data", {27'd0, wr_addr, wr_data}, {27'd0, mon_e});
        end
      end
    end
  end

  // reference model: what the RAM should receive for a load
  task automatic model_load(input int n_raw, input logic [7:0] d[$], output bit e_err, output logic [7:0] ck);
    int n;
    logic [ADDR_W-1:0] a;
    n = (n_raw > DEPTH) ? DEPTH : n_raw;
    ck = 8'h00;
    for (int w = 0; w < n; w++) begin
      a = w[ADDR_W-1:0];
      exp_q.push_back({a, d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]});
      for (int k = 0; k < 4; k++) ck = ck ^ d[4*w+k];
    end
    for (int i = n; i < DEPTH; i++) begin
      a = i[ADDR_W-1:0];
      exp_q.push_back({a, HALT});
    end
    e_err = (n_raw > DEPTH);
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gaps);
    logic rdy;
    if (gaps != 0) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    byte_valid = 1'b1;
    byte_data = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        if (gaps != 0) byte_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_byte_timeout: got byte_ready=0 for 200 cycles expected 1");
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gaps);
    foreach (s[i]) send_byte(s[i], gaps);
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int t = 0; t < max; t++) begin
      @(negedge clk);
      if (done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got done=0 after %0d cycles expected 1", max);
  endtask

  task automatic run_load(input string tag, input int n_raw, input logic [7:0] d[$],
                          input int gaps, input int bad_ck);
    bit e_err;
    logic [7:0] ck;
    logic [7:0] s[$];
    model_load(n_raw, d, e_err, ck);
    s = {};
    s.push_back(8'(n_raw));
    foreach (d[i]) s.push_back(d[i]);
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(ck ^ ((bad_ck != 0) ? 8'h01 : 8'h00));
    if (bad_ck != 0) e_err = 1'b1;
`endif
    do_start();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_hold_after_start"}, cpu_hold, 1);
    check({tag, "_done_cleared"}, done, 0);
    send_stream(s, gaps);
    wait_done(500);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_err"}, err, e_err);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  logic [7:0] t2[$];
  logic [7:0] rd[$];
  logic [7:0] none[$];

  initial begin
    t2 = {8'h93, 8'h00, 8'h00, 8'h01, 8'h23, 8'h20, 8'h10, 8'h00};
    none = {};

    // 1: reset, then idle with no stimulus
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_byte_ready", byte_ready, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_byte_ready", byte_ready, 0);
    check("idle_wr_en", wr_en, 0);
    check("idle_wr_addr", wr_addr, 0);
    check("idle_wr_data", wr_data, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_no_writes", write_cnt, 0);

    // 2: two words then fill
    run_load("t2", 2, t2, 0, 0);
    // 3: empty program
    run_load("t3", 0, none, 0, 0);
    // 4: test 2 with stalls
    run_load("t4", 2, t2, 1, 0);

    // 5: N=40 clamps to DEPTH; trailing bytes stay unconsumed
    rd = {};
    for (int i = 0; i < 4 * DEPTH; i++) rd.push_back(8'($urandom_range(0, 255)));
    xfer_cnt = 0;
    run_load("t5", 40, rd, 0, 0);
    begin
      int hi = 0;
      byte_valid = 1'b1;
      byte_data = 8'($urandom_range(0, 255));
      repeat (40) begin
        @(negedge clk);
        if (byte_ready) hi++;
      end
      byte_valid = 1'b0;
      check("t5_ready_after_clamp", hi, 0);
`ifdef IMEM_LOADER_CKSUM_EN
      check("t5_bytes_taken", xfer_cnt, 1 + 4 * DEPTH + 1);
`else
      check("t5_bytes_taken", xfer_cnt, 1 + 4 * DEPTH);
`endif
    end

    // 6: reset after five stream bytes, then a clean reload
    do_start();
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) send_byte(t2[i], 0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_wr_en", wr_en, 0);
    check("t6_busy", busy, 0);
    check("t6_byte_ready", byte_ready, 0);
    check("t6_cpu_hold", cpu_hold, 1);
    check("t6_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_load("t6_reload", 2, t2, 0, 0);

`ifdef IMEM_LOADER_CKSUM_EN
    // 7: checksum good and bad
    run_load("t7_good", 2, t2, 0, 0);
    run_load("t7_bad", 2, t2, 1, 1);
`endif

    // random loads
    for (int r = 0; r < 4; r++) begin
      int nr;
      int nw;
      nr = $urandom_range(0, 40);
      nw = (nr > DEPTH) ? DEPTH : nr;
      rd = {};
      for (int i = 0; i < 4 * nw; i++) rd.push_back(8'($urandom_range(0, 255)));
      run_load("rand", nr, rd, $urandom_range(0, 1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1, "watchdog");
  end
endmodule
